dma_rc_rx: RTL and testbench

Receive-side counterpart of the DMA request transmitter. It accepts PCIe Requester Completion (RC) packets from the integrated block's 128-bit AXI4-Stream master. It strips the 3-DW completion descriptor and realigns the payload so that payload DW0 sits in bits [31:0]. It then presents the payload, with per-packet completion sideband, to the DMA read-completion consumer through a single-stage output register.

---
 rtl/dma_rc_rx.sv | 272 +++++++++++++++++++++++++++
 tb/tb_dma_rc_rx.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rc_rx.sv
// -----------------------------------------------------------------------------
// dma_rc_rx
//
// Receive side of the DMA engine. Takes PCIe Requester Completion (RC) packets
// from the integrated block's 128-bit AXI4-Stream master. It removes the 3-DW
// completion descriptor and shifts the payload down by one DW so that payload
// DW0 lands in bits [31:0]. The realigned payload goes to the DMA
// read-completion consumer through a single output register, together with
// per-packet sideband taken from the descriptor.
//
// Parameters:
//   ERR_CNT_W          width of the saturating erroneous-packet counter
//
// Ports:
//   clk                sole clock
//   rst                synchronous active-high reset
//   m_axis_rc_tdata    RC beat data (beat 0: DW0-2 descriptor, DW3 payload DW0)
//   m_axis_rc_tuser    RC sideband, not used by the parser
//   m_axis_rc_tkeep    per-DW valid
//   m_axis_rc_tlast    last beat of the packet
//   m_axis_rc_tvalid   beat valid
//   m_axis_rc_tready   beat accept
//   dma_cpl_data       realigned payload
//   dma_cpl_keep       per-DW valid, contiguous from bit 0
//   dma_cpl_last       last payload beat of the packet
//   dma_cpl_valid      output beat valid
//   dma_cpl_ready      consumer accept
//   dma_cpl_tag        descriptor tag          [71:64]
//   dma_cpl_byte_cnt   descriptor byte count   [28:16]
//   dma_cpl_addr_lo    descriptor address low  [11:0]
//   dma_cpl_status     descriptor status       [45:43]
//   dma_cpl_req_done   descriptor request done [30]
//   dma_cpl_err        packet error flag (error code, status or poison)
//   err_cnt            saturating count of erroneous packets
// -----------------------------------------------------------------------------
module dma_rc_rx #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [127:0]         m_axis_rc_tdata,
    input  logic [74:0]          m_axis_rc_tuser,
    input  logic [3:0]           m_axis_rc_tkeep,
    input  logic                 m_axis_rc_tlast,
    input  logic                 m_axis_rc_tvalid,
    output logic                 m_axis_rc_tready,

    output logic [127:0]         dma_cpl_data,
    output logic [3:0]           dma_cpl_keep,
    output logic                 dma_cpl_last,
    output logic                 dma_cpl_valid,
    input  logic                 dma_cpl_ready,

    output logic [7:0]           dma_cpl_tag,
    output logic [12:0]          dma_cpl_byte_cnt,
    output logic [11:0]          dma_cpl_addr_lo,
    output logic [2:0]           dma_cpl_status,
    output logic                 dma_cpl_req_done,
    output logic                 dma_cpl_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Parser states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BODY  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    // Parser state and the one-DW realignment register
    logic [1:0]           r_state;
    logic [31:0]          r_held;
    logic                 r_hv;

    // Output register
    logic [127:0]         r_data;
    logic [3:0]           r_keep;
    logic                 r_last;
    logic                 r_valid;

    // Per-packet sideband, captured from the descriptor on beat 0
    logic [7:0]           r_tag;
    logic [12:0]          r_byte_cnt;
    logic [11:0]          r_addr_lo;
    logic [2:0]           r_status;
    logic                 r_req_done;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    // Combinational control
    logic                 w_out_free;
    logic                 w_tready;
    logic                 w_accept;
    logic                 w_beat0_accept;
    logic                 w_desc_err;
    logic                 w_load;
    logic [127:0]         w_load_data;
    logic [3:0]           w_load_keep;
    logic                 w_load_last;
    logic [1:0]           w_next_state;
    logic [31:0]          w_next_held;
    logic                 w_next_hv;
    logic                 w_unused_tuser;

    // tuser carries nothing the parser needs; folding it keeps it visibly
    // consumed without affecting any output.
    assign w_unused_tuser = ^m_axis_rc_tuser;

    // The output register can take a new beat when it is empty or when its
    // current beat is being drained in this same cycle.
    assign w_out_free = ~r_valid | dma_cpl_ready;

    // No input beats are taken while the trailing flush DW is pending, since
    // that cycle uses the output register for the held DW only.
    assign w_tready       = ~rst & (r_state != S_FLUSH) & w_out_free;
    assign w_accept       = m_axis_rc_tvalid & w_tready;
    assign w_beat0_accept = w_accept & (r_state == S_IDLE);

    // Error code, completion status and poisoned bit all mark a packet bad.
    assign w_desc_err = (|m_axis_rc_tdata[15:12]) |
                        (|m_axis_rc_tdata[45:43]) |
                        m_axis_rc_tdata[46];

    // Realignment datapath and parser next-state. Every body beat shifts by
    // one DW: the DW held from the previous beat becomes output DW0 and the
    // top DW of the current beat is held for the next output.
    always_comb begin
        w_load       = 1'b0;
        w_load_data  = '0;
        w_load_keep  = '0;
        w_load_last  = 1'b0;
        w_next_state = r_state;
        w_next_held  = r_held;
        w_next_hv    = r_hv;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (m_axis_rc_tlast) begin
                        // Single-beat packet: at most one payload DW exists
                        w_load      = 1'b1;
                        w_load_data = {96'b0, m_axis_rc_tdata[127:96]};
                        w_load_keep = {3'b0, m_axis_rc_tkeep[3]};
                        w_load_last = 1'b1;
                        w_next_hv   = 1'b0;
                    end else begin
                        w_next_held  = m_axis_rc_tdata[127:96];
                        w_next_hv    = m_axis_rc_tkeep[3];
                        w_next_state = S_BODY;
                    end
                end
            end

            S_BODY: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_load_data = {m_axis_rc_tdata[95:0], r_held};
                    w_load_keep = {m_axis_rc_tkeep[2:0], r_hv};
                    w_next_held = m_axis_rc_tdata[127:96];
                    w_next_hv   = m_axis_rc_tkeep[3];
                    if (m_axis_rc_tlast) begin
                        // A valid top DW on the last beat spills into one
                        // more output beat, so this one cannot be last.
                        if (m_axis_rc_tkeep[3]) begin
                            w_load_last  = 1'b0;
                            w_next_state = S_FLUSH;
                        end else begin
                            w_load_last  = 1'b1;
                            w_next_hv    = 1'b0;
                            w_next_state = S_IDLE;
                        end
                    end
                end
            end

            S_FLUSH: begin
                if (w_out_free) begin
                    w_load       = 1'b1;
                    w_load_data  = {96'b0, r_held};
                    w_load_keep  = 4'b0001;
                    w_load_last  = 1'b1;
                    w_next_hv    = 1'b0;
                    w_next_state = S_IDLE;
                end
            end

            default: begin
                w_next_state = S_IDLE;
                w_next_hv    = 1'b0;
            end
        endcase
    end

    // Parser state and realignment register. Reset drops any partial packet
    // so the next accepted beat is parsed as a fresh beat 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_held  <= '0;
            r_hv    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_held  <= w_next_held;
            r_hv    <= w_next_hv;
        end
    end

    // Single-stage output register. It only loads when free, and clears its
    // valid when the consumer drains it with nothing new behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= w_load_data;
            r_keep  <= w_load_keep;
            r_last  <= w_load_last;
            r_valid <= 1'b1;
        end else if (dma_cpl_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sideband is captured only on beat-0 accept. Beat 0 is accepted only
    // when the previous packet's final output is leaving the register (or
    // already gone), so these values never change under a pending beat of
    // an older packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag      <= '0;
            r_byte_cnt <= '0;
            r_addr_lo  <= '0;
            r_status   <= '0;
            r_req_done <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_beat0_accept) begin
            r_tag      <= m_axis_rc_tdata[71:64];
            r_byte_cnt <= m_axis_rc_tdata[28:16];
            r_addr_lo  <= m_axis_rc_tdata[11:0];
            r_status   <= m_axis_rc_tdata[45:43];
            r_req_done <= m_axis_rc_tdata[30];
            r_err      <= w_desc_err;
        end
    end

    // Erroneous-packet counter: one count per bad packet, taken at beat 0,
    // holding at all-ones once saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_beat0_accept && w_desc_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_ONE;
        end
    end

    assign m_axis_rc_tready = w_tready;
    assign dma_cpl_data     = r_data;
    assign dma_cpl_keep     = r_keep;
    assign dma_cpl_last     = r_last;
    assign dma_cpl_valid    = r_valid;
    assign dma_cpl_tag      = r_tag;
    assign dma_cpl_byte_cnt = r_byte_cnt;
    assign dma_cpl_addr_lo  = r_addr_lo;
    assign dma_cpl_status   = r_status;
    assign dma_cpl_req_done = r_req_done;
    assign dma_cpl_err      = r_err;
    assign err_cnt          = r_err_cnt;

endmodule

// File: tb/tb_dma_rc_rx.sv
// -----------------------------------------------------------------------------
// tb_dma_rc_rx
//
// Self-checking bench for dma_rc_rx. Packets are built from random payload
// and descriptor fields; the expected realigned output beats are pushed onto a
// scoreboard queue as each packet is driven, and a monitor pops and compares
// them whenever the DUT hands a beat to the consumer.
// -----------------------------------------------------------------------------
module tb_dma_rc_rx;

    localparam int ERR_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [127:0]     m_axis_rc_tdata = '0;
    logic [74:0]      m_axis_rc_tuser = '0;
    logic [3:0]       m_axis_rc_tkeep = '0;
    logic             m_axis_rc_tlast = 1'b0;
    logic             m_axis_rc_tvalid = 1'b0;
    logic             m_axis_rc_tready;
    logic [127:0]     dma_cpl_data;
    logic [3:0]       dma_cpl_keep;
    logic             dma_cpl_last;
    logic             dma_cpl_valid;
    logic             dma_cpl_ready = 1'b0;
    logic [7:0]       dma_cpl_tag;
    logic [12:0]      dma_cpl_byte_cnt;
    logic [11:0]      dma_cpl_addr_lo;
    logic [2:0]       dma_cpl_status;
    logic             dma_cpl_req_done;
    logic             dma_cpl_err;
    logic [ERR_W-1:0] err_cnt;

    dma_rc_rx #(.ERR_CNT_W(ERR_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .m_axis_rc_tdata  (m_axis_rc_tdata),
        .m_axis_rc_tuser  (m_axis_rc_tuser),
        .m_axis_rc_tkeep  (m_axis_rc_tkeep),
        .m_axis_rc_tlast  (m_axis_rc_tlast),
        .m_axis_rc_tvalid (m_axis_rc_tvalid),
        .m_axis_rc_tready (m_axis_rc_tready),
        .dma_cpl_data     (dma_cpl_data),
        .dma_cpl_keep     (dma_cpl_keep),
        .dma_cpl_last     (dma_cpl_last),
        .dma_cpl_valid    (dma_cpl_valid),
        .dma_cpl_ready    (dma_cpl_ready),
        .dma_cpl_tag      (dma_cpl_tag),
        .dma_cpl_byte_cnt (dma_cpl_byte_cnt),
        .dma_cpl_addr_lo  (dma_cpl_addr_lo),
        .dma_cpl_status   (dma_cpl_status),
        .dma_cpl_req_done (dma_cpl_req_done),
        .dma_cpl_err      (dma_cpl_err),
        .err_cnt          (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   keep;
        logic         last;
        logic [7:0]   tag;
        logic [12:0]  byteCnt;
        logic [11:0]  addrLo;
        logic [2:0]   status;
        logic         reqDone;
        logic         err;
    } expBeat_t;

    expBeat_t     expQ[$];
    int           checks = 0;
    int           failures = 0;
    bit           readyRandom = 1'b0;
    int           lowReadyCycles = 0;
    expBeat_t     monExp;
    logic [127:0] monMask;

    // Random consumer back-pressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (readyRandom) dma_cpl_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard consumer: every handshake pops one expected beat
    always @(negedge clk) begin
        if (!rst && !m_axis_rc_tready) lowReadyCycles++;
        if (!rst && dma_cpl_valid && dma_cpl_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_beat got data=%h keep=%b last=%b, required no beat",
                         dma_cpl_data, dma_cpl_keep, dma_cpl_last);
            end else begin
                monExp = expQ.pop_front();
                for (int i = 0; i < 4; i++) monMask[32*i +: 32] = {32{monExp.keep[i]}};
                checks++;
                if (((dma_cpl_data & monMask) !== (monExp.data & monMask)) ||
                    (dma_cpl_keep !== monExp.keep) || (dma_cpl_last !== monExp.last)) begin
                    failures++;
                    $display("[TB] FAIL payload got data=%h keep=%b last=%b required data=%h keep=%b last=%b",
                             dma_cpl_data & monMask, dma_cpl_keep, dma_cpl_last,
                             monExp.data & monMask, monExp.keep, monExp.last);
                end
                checks++;
                if ({dma_cpl_tag, dma_cpl_byte_cnt, dma_cpl_addr_lo, dma_cpl_status,
                     dma_cpl_req_done, dma_cpl_err} !==
                    {monExp.tag, monExp.byteCnt, monExp.addrLo, monExp.status,
                     monExp.reqDone, monExp.err}) begin
                    failures++;
                    $display("[TB] FAIL sideband got tag=%h bc=%h addr=%h st=%b rd=%b err=%b required tag=%h bc=%h addr=%h st=%b rd=%b err=%b",
                             dma_cpl_tag, dma_cpl_byte_cnt, dma_cpl_addr_lo, dma_cpl_status,
                             dma_cpl_req_done, dma_cpl_err, monExp.tag, monExp.byteCnt,
                             monExp.addrLo, monExp.status, monExp.reqDone, monExp.err);
                end
            end
        end
    end

    // Present one beat and hold it until accepted (bounded)
    task automatic drive_beat(input logic [127:0] data, input logic [3:0] keep, input logic last);
        bit acc;
        int waited;
        acc = 1'b0;
        waited = 0;
        m_axis_rc_tdata  = data;
        m_axis_rc_tkeep  = keep;
        m_axis_rc_tlast  = last;
        m_axis_rc_tvalid = 1'b1;
        while (!acc && waited < 1000) begin
            @(negedge clk);
            acc = m_axis_rc_tready;
            @(posedge clk);
            #1;
            waited++;
        end
        m_axis_rc_tvalid = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("[TB] FAIL beat_accept_timeout got tready=0 for %0d cycles, required accept", waited);
        end
    endtask

    // Build a packet, push its expected output beats, then drive it
    task automatic send_packet(input logic [7:0] tag, input logic [2:0] status,
                               input logic [3:0] errCode, input logic poison,
                               input logic reqDone, input int ndw, input bit gaps);
        logic [95:0]  desc;
        logic [31:0]  s[0:71];
        logic [12:0]  bc;
        logic [11:0]  addr;
        logic [127:0] bd;
        logic [3:0]   kp;
        expBeat_t     e;
        int           total;
        int           nb;
        int           nOut;
        int           idx;
        bc   = 13'($urandom_range(0, 8191));
        addr = 12'($urandom_range(0, 4095));
        desc = {$urandom(), $urandom(), $urandom()};
        desc[11:0]  = addr;
        desc[15:12] = errCode;
        desc[28:16] = bc;
        desc[30]    = reqDone;
        desc[45:43] = status;
        desc[46]    = poison;
        desc[71:64] = tag;
        s[0] = desc[31:0];
        s[1] = desc[63:32];
        s[2] = desc[95:64];
        for (int k = 0; k < ndw; k++) s[3+k] = $urandom();
        total = 3 + ndw;
        nb    = (total + 3) / 4;

        e.tag     = tag;
        e.byteCnt = bc;
        e.addrLo  = addr;
        e.status  = status;
        e.reqDone = reqDone;
        e.err     = (errCode != 4'd0) || (status != 3'd0) || poison;
        if (ndw == 0) begin
            e.data = '0;
            e.keep = 4'b0000;
            e.last = 1'b1;
            expQ.push_back(e);
        end else begin
            nOut = (ndw + 3) / 4;
            for (int j = 0; j < nOut; j++) begin
                for (int i = 0; i < 4; i++) begin
                    idx = 4*j + i;
                    e.data[32*i +: 32] = (idx < ndw) ? s[3+idx] : 32'h0;
                    e.keep[i]          = (idx < ndw);
                end
                e.last = (j == nOut - 1);
                expQ.push_back(e);
            end
        end

        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 4; i++) begin
                idx = 4*b + i;
                bd[32*i +: 32] = (idx < total) ? s[idx] : $urandom();
                kp[i]          = (idx < total);
            end
            if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
            drive_beat(bd, kp, (b == nb - 1));
        end
    endtask

    // Wait for the scoreboard to empty (bounded)
    task automatic wait_drain();
        int waited;
        waited = 0;
        while (expQ.size() != 0 && waited < 3000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain got %0d beats outstanding, required 0", expQ.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dma_cpl_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (m_axis_rc_tready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_tready got %b required 0", m_axis_rc_tready);
        end
        checks++;
        if ({dma_cpl_valid, dma_cpl_last, dma_cpl_keep, dma_cpl_data} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_output got valid=%b last=%b keep=%b data=%h required all 0",
                     dma_cpl_valid, dma_cpl_last, dma_cpl_keep, dma_cpl_data);
        end
        checks++;
        if ({dma_cpl_tag, dma_cpl_byte_cnt, dma_cpl_addr_lo, dma_cpl_status,
             dma_cpl_req_done, dma_cpl_err, err_cnt} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_sideband got tag=%h st=%b err=%b err_cnt=%0d required all 0",
                     dma_cpl_tag, dma_cpl_status, dma_cpl_err, err_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_dw();
        dma_cpl_ready = 1'b1;
        send_packet(8'h05, 3'd0, 4'd0, 1'b0, 1'b1, 1, 1'b0);
        wait_drain();
    endtask

    task automatic test_eight_dw();
        int lowBefore;
        dma_cpl_ready = 1'b1;
        lowBefore = lowReadyCycles;
        send_packet(8'h21, 3'd0, 4'd0, 1'b0, 1'b0, 8, 1'b0);
        wait_drain();
        checks++;
        if (lowReadyCycles - lowBefore != 0) begin
            failures++;
            $display("[TB] FAIL eight_dw_no_flush got %0d tready-low cycles required 0",
                     lowReadyCycles - lowBefore);
        end
    endtask

    task automatic test_nine_dw_flush();
        int lowBefore;
        dma_cpl_ready = 1'b1;
        lowBefore = lowReadyCycles;
        send_packet(8'h42, 3'd0, 4'd0, 1'b0, 1'b1, 9, 1'b0);
        wait_drain();
        checks++;
        if (lowReadyCycles - lowBefore != 1) begin
            failures++;
            $display("[TB] FAIL nine_dw_flush_stall got %0d tready-low cycles required 1",
                     lowReadyCycles - lowBefore);
        end
    endtask

    task automatic test_error_status();
        dma_cpl_ready = 1'b1;
        send_packet(8'h77, 3'b001, 4'd0, 1'b0, 1'b1, 0, 1'b0);
        checks++;
        if (err_cnt !== 2'd1) begin
            failures++;
            $display("[TB] FAIL err_cnt_first got %0d required 1", err_cnt);
        end
        wait_drain();
    endtask

    task automatic test_err_saturation();
        dma_cpl_ready = 1'b1;
        send_packet(8'h10, 3'b010, 4'd0, 1'b0, 1'b0, 0, 1'b0);
        send_packet(8'h11, 3'b000, 4'h3, 1'b0, 1'b0, 2, 1'b0);
        send_packet(8'h12, 3'b000, 4'd0, 1'b1, 1'b1, 5, 1'b0);
        send_packet(8'h13, 3'b100, 4'h1, 1'b1, 1'b0, 1, 1'b0);
        checks++;
        if (err_cnt !== 2'd3) begin
            failures++;
            $display("[TB] FAIL err_cnt_saturate got %0d required 3", err_cnt);
        end
        wait_drain();
    endtask

    task automatic test_random_ready();
        bit isErr;
        readyRandom = 1'b1;
        for (int n = 0; n < 100; n++) begin
            isErr = ($urandom_range(0, 4) == 0);
            send_packet(8'($urandom_range(0, 255)),
                        isErr ? 3'($urandom_range(0, 7)) : 3'd0,
                        isErr ? 4'($urandom_range(1, 15)) : 4'd0,
                        isErr ? 1'($urandom_range(0, 1)) : 1'b0,
                        1'($urandom_range(0, 1)),
                        $urandom_range(0, 20), 1'b1);
        end
        wait_drain();
        readyRandom = 1'b0;
        dma_cpl_ready = 1'b1;
        checks++;
        if (err_cnt !== 2'd3) begin
            failures++;
            $display("[TB] FAIL err_cnt_hold got %0d required 3", err_cnt);
        end
    endtask

    task automatic test_reset_mid_body();
        logic [127:0] d0;
        logic [127:0] d1;
        dma_cpl_ready = 1'b0;
        d0 = {$urandom(), $urandom(), $urandom(), $urandom()};
        d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        d0[46] = 1'b1;
        drive_beat(d0, 4'b1111, 1'b0);
        drive_beat(d1, 4'b1111, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (dma_cpl_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_valid got %b required 0", dma_cpl_valid);
        end
        checks++;
        if (err_cnt !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_err_cnt got %0d required 0", err_cnt);
        end
        dma_cpl_ready = 1'b1;
        send_packet(8'h9C, 3'd0, 4'd0, 1'b0, 1'b1, 5, 1'b0);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_single_dw();
        test_eight_dw();
        test_nine_dw_flush();
        test_error_status();
        test_err_saturation();
        test_random_ready();
        test_reset_mid_body();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
